// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending dispense sequencer.
// States, product-code width and default cycle constants.
package vend_pkg;

  localparam int PROD_W          = 3;
  localparam int DEF_N_PROD      = 8;
  localparam int DEF_MOTOR_CYC   = 16;
  localparam int DEF_TIMEOUT_CYC = 32;
  localparam int DEF_MAX_RETRY   = 1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT_DROP,
    DONE,
    FAULT
  } state_t;

  // Counter width large enough to hold the longer of the two intervals.
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/vend_cycle_timer.sv
// Loadable saturating down-counter shared by the RUN and WAIT_DROP phases.
// expired marks the last cycle of the loaded interval.
module vend_cycle_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt <= W'(1));

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Motor/drop-sensor sequencer behind the vending FSM.
// Optional SEQ_RETRY_EN allows MAX_RETRY extra motor attempts.
module vend_dispense_sequencer
  import vend_pkg::*;
#(
  parameter int N_PROD      = DEF_N_PROD,
  parameter int MOTOR_CYC   = DEF_MOTOR_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [PROD_W-1:0] prod_sel,
  input  logic              drop_sense,
  input  logic              clr_fault,
  output logic [N_PROD-1:0] motor_en,
  output logic              busy,
  output logic              disp_ack,
  output logic              refund,
  output logic              fault
);

  localparam int CW = cnt_w(MOTOR_CYC, TIMEOUT_CYC);
  localparam logic [CW-1:0] MOTOR_V   = CW'(MOTOR_CYC);
  localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT_CYC);

  state_t            state, state_d;
  logic [PROD_W-1:0] sel_q, sel_d;
  logic [N_PROD-1:0] sel_oh;
  logic              code_ok;
  logic              t_load, t_en, t_exp;
  logic [CW-1:0]     t_val;
  logic              retry_avail;

  logic [N_PROD-1:0] motor_d;
  logic              busy_d, ack_d, refund_d, fault_d;

  vend_cycle_timer #(
    .W(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .load_val(t_val),
    .en      (t_en),
    .expired (t_exp)
  );

  assign code_ok = (int'(prod_sel) < N_PROD);
  assign sel_oh  = {{(N_PROD-1){1'b0}}, 1'b1} << sel_d;

`ifdef SEQ_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);

  logic [RW-1:0] retry_q;
  logic          retry_inc, retry_clr;

  assign retry_inc = (state == WAIT_DROP) && !drop_sense
                   && t_exp && retry_avail;
  assign retry_clr = (state == DONE)
                   || ((state == FAULT) && clr_fault);

  always_ff @(posedge clk) begin
    if (rst || retry_clr) begin
      retry_q <= '0;
    end else if (retry_inc) begin
      retry_q <= retry_q + 1'b1;
    end
  end

  assign retry_avail = (retry_q < RW'(MAX_RETRY));
`else
  // Retries compiled out: the limit is pinned at zero.
  localparam int RETRY_LIM = 0 * MAX_RETRY;

  assign retry_avail = (RETRY_LIM > 0);
`endif

  always_comb begin
    state_d  = state;
    sel_d    = sel_q;
    t_load   = 1'b0;
    t_val    = MOTOR_V;
    t_en     = 1'b0;
    refund_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (disp_req && code_ok) begin
          state_d = RUN;
          sel_d   = prod_sel;
          t_load  = 1'b1;
        end else if (disp_req) begin
          refund_d = 1'b1;
        end
      end
      RUN: begin
        t_en = 1'b1;
        if (drop_sense) begin
          state_d = DONE;
        end else if (t_exp) begin
          state_d = WAIT_DROP;
          t_load  = 1'b1;
          t_val   = TIMEOUT_V;
        end
      end
      WAIT_DROP: begin
        t_en = 1'b1;
        if (drop_sense) begin
          state_d = DONE;
        end else if (t_exp && retry_avail) begin
          state_d = RUN;
          t_load  = 1'b1;
        end else if (t_exp) begin
          state_d  = FAULT;
          refund_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        if (clr_fault) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the state being entered.
    motor_d = (state_d == RUN) ? sel_oh : '0;
    busy_d  = (state_d != IDLE);
    ack_d   = (state_d == DONE);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= '0;
      motor_en <= '0;
      busy     <= 1'b0;
      disp_ack <= 1'b0;
      refund   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_d;
      sel_q    <= sel_d;
      motor_en <= motor_d;
      busy     <= busy_d;
      disp_ack <= ack_d;
      refund   <= refund_d;
      fault    <= fault_d;
    end
  end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Randomized bench for vend_dispense_sequencer against a
// window-arithmetic model of each dispense transaction.
module tb_vend_dispense_sequencer;

  localparam int NP   = 5;
  localparam int M    = 16;
  localparam int T    = 32;
  localparam int MR   = 1;
`ifdef SEQ_RETRY_EN
  localparam int R    = MR;
`else
  localparam int R    = 0;
`endif
  localparam int MAXC = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [2:0]    prod_sel;
  logic          drop_sense;
  logic          clr_fault;
  logic [NP-1:0] motor_en;
  logic          busy, disp_ack, refund, fault;

  vend_dispense_sequencer #(
    .N_PROD     (NP),
    .MOTOR_CYC  (M),
    .TIMEOUT_CYC(T),
    .MAX_RETRY  (MR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_req  (disp_req),
    .prod_sel  (prod_sel),
    .drop_sense(drop_sense),
    .clr_fault (clr_fault),
    .motor_en  (motor_en),
    .busy      (busy),
    .disp_ack  (disp_ack),
    .refund    (refund),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // ec = number of rising edges so far; index = edge that produced a value
  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  bit   [NP-1:0] x_m [MAXC];
  bit            x_b [MAXC];
  bit            x_a [MAXC];
  bit            x_r [MAXC];
  bit            x_f [MAXC];
  logic [NP-1:0] l_m [MAXC];
  logic          l_b [MAXC];
  logic          l_a [MAXC];
  logic          l_r [MAXC];
  logic          l_f [MAXC];

  int n_pass = 0;
  int n_tot  = 0;
  int motor_hi = 0;
  int ref_cnt  = 0;
  int ack_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit [NP-1:0] oh(input int s);
    bit [NP-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (ec < MAXC) begin
      l_m[ec] = motor_en;
      l_b[ec] = busy;
      l_a[ec] = disp_ack;
      l_r[ec] = refund;
      l_f[ec] = fault;
      if (motor_en != '0) motor_hi++;
      if (refund) ref_cnt++;
      if (disp_ack) ack_cnt++;
      chk($sformatf("cyc%0d m/b/a/r/f", ec),
          32'({motor_en, busy, disp_ack, refund, fault}),
          32'({x_m[ec], x_b[ec], x_a[ec], x_r[ec], x_f[ec]}));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      disp_req   = 1'b0;
      prod_sel   = 3'($urandom_range(0, 7));
      drop_sense = 1'($urandom_range(0, 1));
      clr_fault  = 1'($urandom_range(0, 1));
      rst        = 1'b0;
      @(posedge clk);
      #1;
    end
    drop_sense = 1'b0;
    clr_fault  = 1'b0;
  endtask

  // One request at the next edge t. doff: drop edge offset from t (<=0 none);
  // cgap: edges in FAULT before clr_fault; roff: reset edge offset (0 none).
  task automatic run_txn(input int sel, input int doff, input int cgap,
                         input int roff, input bit noise,
                         output int t, output int endE);
    int  e, last, f, r, stop;
    bit  got;
    t    = ec + 1;
    endE = t + (R + 1) * (M + T);
    e    = (doff > 0) ? t + doff : -1;
    f    = -1;
    if (sel >= NP) begin
      x_r[t] = 1'b1;
      last   = t;
    end else begin
      got  = (e >= t + 1) && (e <= endE);
      stop = got ? e : endE;
      for (int c = t; c < stop; c++) begin
        if (((c - t) % (M + T)) < M) x_m[c] = oh(sel);
        x_b[c] = 1'b1;
      end
      if (got) begin
        x_b[e] = 1'b1;
        x_a[e] = 1'b1;
        last   = e + 1;
      end else begin
        f = endE + cgap;
        for (int c = endE; c < f; c++) begin
          x_b[c] = 1'b1;
          x_f[c] = 1'b1;
        end
        x_r[endE] = 1'b1;
        last      = f;
      end
    end
    r = -1;
    if (roff > 0) begin
      r = (t + roff > last) ? last : t + roff;
      for (int c = r; c <= last; c++) begin
        x_m[c] = '0;
        x_b[c] = 1'b0;
        x_a[c] = 1'b0;
        x_r[c] = 1'b0;
        x_f[c] = 1'b0;
      end
      last = r;
    end
    for (int x = t; x <= last; x++) begin
      disp_req   = (x == t) || (noise && x > t && ($urandom_range(0, 3) == 0));
      prod_sel   = (x == t) ? 3'(sel) : 3'($urandom_range(0, 7));
      drop_sense = (x == e);
      clr_fault  = (x == f) ||
                   (noise && x <= endE && ($urandom_range(0, 3) == 0));
      rst        = (x == r);
      @(posedge clk);
      #1;
    end
    disp_req   = 1'b0;
    drop_sense = 1'b0;
    clr_fault  = 1'b0;
    rst        = 1'b0;
  endtask

  initial begin
    int t, en, mh, rc, ac, sel, doff, roff;
    rst = 1'b1; disp_req = 1'b0; prod_sel = '0;
    drop_sense = 1'b0; clr_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", 32'(l_b[2]), 32'(0));
    chk("reset_motor", 32'(l_m[2]), 32'(0));
    idle(2);

    // Normal dispense, drop 10 edges after the request
    run_txn(3, 10, 0, 0, 0, t, en);
    idle(3);
    chk("norm_motor_first", 32'(l_m[t]), 32'(5'b01000));
    chk("norm_motor_last", 32'(l_m[t+9]), 32'(5'b01000));
    chk("norm_motor_off", 32'(l_m[t+10]), 32'(0));
    chk("norm_ack", 32'(l_a[t+10]), 32'(1));
    chk("norm_busy_ack", 32'(l_b[t+10]), 32'(1));
    chk("norm_busy_low", 32'(l_b[t+11]), 32'(0));

    // Full motor run, drop 5 edges into WAIT_DROP
    mh = motor_hi; rc = ref_cnt;
    run_txn(1, M + 5, 0, 0, 1, t, en);
    idle(3);
    chk("late_motor_cycles", 32'(motor_hi - mh), 32'(16));
    chk("late_ack", 32'(l_a[t+21]), 32'(1));
    chk("late_no_refund", 32'(ref_cnt - rc), 32'(0));

    // Timeout to FAULT, disp_req noise ignored, clear after 7 edges
    mh = motor_hi; rc = ref_cnt; ac = ack_cnt;
    run_txn(4, -1, 7, 0, 1, t, en);
    idle(3);
    chk("flt_motor_cycles", 32'(motor_hi - mh), 32'(16 * (R + 1)));
    chk("flt_entry_edge", 32'(en - t), 32'(48 * (R + 1)));
    chk("flt_fault", 32'(l_f[en]), 32'(1));
    chk("flt_refund", 32'(l_r[en]), 32'(1));
    chk("flt_refund_once", 32'(ref_cnt - rc), 32'(1));
    chk("flt_no_ack", 32'(ack_cnt - ac), 32'(0));
    chk("flt_cleared", 32'({l_b[en+7], l_f[en+7]}), 32'(0));

`ifdef SEQ_RETRY_EN
    // Drop during the second motor burst
    mh = motor_hi; rc = ref_cnt;
    run_txn(2, M + T + 3, 0, 0, 0, t, en);
    idle(3);
    chk("retry_ack", 32'(l_a[t+51]), 32'(1));
    chk("retry_motor_cycles", 32'(motor_hi - mh), 32'(19));
    chk("retry_no_refund", 32'(ref_cnt - rc), 32'(0));
`endif

    // Invalid product code
    run_txn(6, -1, 0, 0, 0, t, en);
    idle(3);
    chk("inv_refund", 32'(l_r[t]), 32'(1));
    chk("inv_refund_pulse", 32'(l_r[t+1]), 32'(0));
    chk("inv_motor", 32'(l_m[t]), 32'(0));
    chk("inv_busy", 32'(l_b[t]), 32'(0));

    // Reset four edges into RUN, then a normal request
    rc = ref_cnt; ac = ack_cnt;
    run_txn(3, -1, 0, 4, 0, t, en);
    idle(2);
    chk("rst_motor_before", 32'(l_m[t+3]), 32'(5'b01000));
    chk("rst_motor_after", 32'(l_m[t+4]), 32'(0));
    chk("rst_busy_after", 32'(l_b[t+4]), 32'(0));
    chk("rst_no_pulses", 32'((ref_cnt - rc) + (ack_cnt - ac)), 32'(0));
    run_txn(0, 3, 0, 0, 0, t, en);
    idle(3);
    chk("post_rst_ack", 32'(l_a[t+3]), 32'(1));
    chk("post_rst_motor", 32'(l_m[t]), 32'(5'b00001));

    for (int i = 0; i < 60 && ec < MAXC - 400; i++) begin
      sel  = $urandom_range(0, 7);
      doff = ($urandom_range(0, 3) == 0) ? -1 :
             $urandom_range(1, (R + 1) * (M + T) + 5);
      roff = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 60) : 0;
      run_txn(sel, doff, $urandom_range(1, 6), roff, 1, t, en);
      idle($urandom_range(1, 4));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/vend_dispense_sequencer.md
Name: vend_dispense_sequencer

Overview:
- Sequences the physical product-release stage behind the vending FSM.
- When the FSM asserts its dispense signal with a product code, this block:
  - drives the matching motor line for a fixed time;
  - waits for the drop sensor;
  - retries or faults on timeout;
  - reports completion or refund back to the FSM.
- Sits between fsm_top (d, p outputs) and the chip's motor/sensor pins.

Parameters:
- N_PROD, 8, number of product slots; motor_en width; valid codes 0..N_PROD-1.
- MOTOR_CYC, 16, cycles motor_en is held high per attempt (>=1).
- TIMEOUT_CYC, 32, cycles to wait for drop_sense after the motor stops (>=1).
- MAX_RETRY, 1, extra motor attempts after a timeout (only used with SEQ_RETRY_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  dispense request from FSM; sampled only in IDLE.
- prod_sel  in  3  product code; latched with disp_req.
- drop_sense  in  1  product-drop sensor, active high.
- clr_fault  in  1  clears FAULT state.
- motor_en  out  N_PROD  one-hot motor drive, registered.
- busy  out  1  high in every state except IDLE.
- disp_ack  out  1  one-cycle pulse: product dropped.
- refund  out  1  one-cycle pulse: credit must be returned.
- fault  out  1  high while in FAULT.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: state=IDLE, motor_en=0, busy=0, disp_ack=0, refund=0, fault=0, counters=0, retry count=0.
- States: IDLE, RUN, WAIT_DROP, DONE, FAULT.
- IDLE:
  - If disp_req=1 at edge t and prod_sel<N_PROD: latch prod_sel; go to RUN.
  - From t+1, motor_en has bit prod_sel set, busy=1.
  - If prod_sel>=N_PROD: stay IDLE and pulse refund at t+1; no motor activity, no ack.
- RUN:
  - Motor held exactly MOTOR_CYC cycles, then WAIT_DROP with motor_en=0.
  - drop_sense=1 in any RUN cycle goes to DONE immediately; motor_en=0 the next cycle.
- WAIT_DROP:
  - Timer loads TIMEOUT_CYC.
  - drop_sense=1 goes to DONE.
  - When the timer expires without a drop:
    - if a retry is available, retry count++ and return to RUN;
    - otherwise go to FAULT.
- DONE: one cycle; disp_ack=1; retry count cleared; return to IDLE. busy falls on the cycle after disp_ack.
- FAULT:
  - fault=1, busy=1, motor_en=0.
  - refund pulses on the entry cycle only.
  - disp_req is ignored.
  - clr_fault=1 goes to IDLE next cycle.
- disp_req while busy is ignored, with no queueing. The FSM must hold or re-issue it.
- drop_sense and timer expiry on the same cycle: drop wins, go to DONE.
- rst mid-operation: motor_en=0 at the next edge; no ack or refund emitted.
- Counters are sized $clog2(max(MOTOR_CYC,TIMEOUT_CYC))+1 and never wrap. They saturate at 0.

Optional Feature:
- Macro: SEQ_RETRY_EN.
- Defined: timeout allows up to MAX_RETRY additional RUN attempts before FAULT.
- Undefined: the first timeout goes straight to FAULT, and MAX_RETRY is ignored. No retry counter is synthesized.

Decomposition:
- Package vend_pkg holds:
  - state enum (IDLE, RUN, WAIT_DROP, DONE, FAULT);
  - PROD_W=3;
  - default cycle constants.
- One sub-module, vend_cycle_timer:
  - loadable down-counter with load, load_val, en, expired;
  - instanced once and shared by RUN and WAIT_DROP.

Test Plan:
- Normal dispense: rst then disp_req=1, prod_sel=3 at t, drop_sense at t+10 → motor_en=8'b0000_1000 over t+1..t+10, disp_ack pulse at t+11, busy=0 at t+12.
- Full-length run with late drop: no drop in RUN, drop_sense 5 cycles into WAIT_DROP → motor high exactly 16 cycles, then disp_ack, refund never asserted.
- Timeout without SEQ_RETRY_EN: no drop_sense → 16 motor cycles, 32 wait cycles, FAULT with fault=1 and one refund pulse; disp_req=1 ignored; clr_fault=1 → IDLE, fault=0.
- Timeout with SEQ_RETRY_EN and MAX_RETRY=1: no drop → two 16-cycle motor bursts, then FAULT. Same test with drop during the second burst → disp_ack, no refund.
- Invalid code with N_PROD=5: prod_sel=6 → refund pulse next cycle, motor_en=0, busy=0.
- Reset mid-RUN: rst at RUN cycle 4 → motor_en=0 next edge, state IDLE, no disp_ack/refund; next disp_req works normally.
